fence_area: RTL
===============

# fence_area

Downstream consumer of the fence-sorting stage. It collects the six sorted, origin-relative receiver vertices streamed out by the sorter and computes the enclosed polygon area with the shoelace formula, one cross term per cycle. It reports the area, a half-unit flag and the winding direction, then returns to collection for the next fence.

## Interface
- `NV`, 6: vertices per fence. The design is fixed at 6; other values are unsupported.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset; clock `clk`.
- `in_valid`  in  1  vertex beat qualifier; one vertex per high cycle.
- `inX`  in  8  signed two's-complement vertex X, relative to vertex 0.
- `inY`  in  8  signed two's-complement vertex Y.
- `busy`  out  1  high while not accepting vertices (ACCUM/FINAL).
- `area`  out  19  unsigned floor(|S|/2), where S = shoelace sum.
- `area_half`  out  1  S is odd; the true area is `area` + 0.5.
- `ccw`  out  1  S > 0, i.e. the vertices are counter-clockwise; 0 for S ≤ 0.
- `area_valid`  out  1  single-cycle strobe qualifying `area`/`area_half`/`ccw`.

## Operation
- Storage: vertex arrays vx[0:5], vy[0:5] (signed 8 bit), index `cnt` (3 bit), term index `k` (3 bit), accumulator `acc` (signed 20 bit).
- COLLECT:
  - Each cycle with `in_valid` high stores (inX, inY) at vx/vy[cnt] and increments `cnt`.
  - Gaps in `in_valid` are allowed.
  - When the 6th vertex is stored: cnt←0, k←0, acc←0, go to ACCUM.
- ACCUM: each cycle acc ← acc + (vx[k]·vy[k⁺] − vx[k⁺]·vy[k]), where k⁺ = (k==5) ? 0 : k+1 (wrap-around).
  - Products are signed 16 bit; each term is signed 17 bit, sign-extended to 20 bit.
  - After k==5: go to FINAL.
- FINAL (1 cycle):
  - area ← |acc|[19:1], area_half ← acc[0], ccw ← (acc > 0), area_valid ← 1.
  - Go to COLLECT.
- Any state other than FINAL drives area_valid ← 0. `area`, `area_half` and `ccw` hold their value until the next FINAL.
- `in_valid` while `busy` is ignored: data is dropped, with no queuing and no error.
- Range: |S| ≤ 6·32768, which fits signed 20 bit with no overflow. Full-scale inputs (−128..127) must be exact.
- Degenerate polygons (repeated or collinear points) are legal and produce whatever S gives. S=0 → area 0, half 0, ccw 0.

## Timing
- Reset (async, immediate):
  - State COLLECT; cnt, k and acc = 0; vertex arrays = 0.
  - area = 0, area_half = 0, ccw = 0, area_valid = 0, busy = 0.
- Reset asserted mid-ACCUM/FINAL aborts the computation. No area_valid is produced for that fence, and the partial vertex count is discarded.
- Let edge E0 be the edge that captures the 6th vertex:
  - busy = 1 after E0.
  - ACCUM terms are added on E1..E6.
  - E7 registers the results and sets area_valid = 1, busy = 0.
  - E8 clears area_valid.
  - Latency from 6th-vertex capture to strobe is 7 cycles.
- The first vertex of the next fence may be presented in the cycle following E7; it is sampled on E8. Minimum frame period is 13 cycles.
- `busy` is a registered output derived from state. `area_valid` is high for exactly one cycle per fence.

## Test plan
- Hexagon (0,0),(4,0),(6,2),(4,4),(0,4),(−2,2) on consecutive cycles → S=48:
  - area=24, area_half=0, ccw=1.
  - area_valid pulses exactly 7 cycles after the 6th beat.
- Same six vertices in reverse order → S=−48: area=24, area_half=0, ccw=0.
- (0,0),(1,0),(0,1),(0,1),(0,1),(0,1) → S=1: area=0, area_half=1, ccw=1.
- Full scale (−128,−128),(127,−128),(127,127),(−128,127),(−128,127),(−128,127) → S=130050: area=65025, area_half=0, ccw=1.
- Hexagon vertices with random 0–3 cycle `in_valid` gaps, plus extra `in_valid` beats of (99,99) driven while busy:
  - Result is unchanged (area=24).
  - Dropped beats do not corrupt the next fence.
- Reset pulse at E3 of a fence:
  - All outputs read 0 and no strobe appears.
  - A following reversed-hexagon fence yields area=24, ccw=0.
- Two fences back-to-back at the minimum 13-cycle period each produce a correct strobe.

Source files
------------

// File: rtl/fence_area_if.sv
// Vertex stream and area result bundle between the fence sorter and fence_area.
// The master drives the vertices and the slave computes the area.
interface fence_area_if;
    logic              in_valid;
    logic signed [7:0] inX;
    logic signed [7:0] inY;
    logic              busy;
    logic [18:0]       area;
    logic              area_half;
    logic              ccw;
    logic              area_valid;

    modport master (
        output in_valid, inX, inY,
        input  busy, area, area_half, ccw, area_valid
    );

    modport slave (
        input  in_valid, inX, inY,
        output busy, area, area_half, ccw, area_valid
    );
endinterface

// File: rtl/fence_area.sv
// Shoelace area of a six-vertex fence polygon, one cross term per cycle.
// Reports |S|/2, the half-unit bit and the winding direction.
module fence_area #(
    parameter int NV = 6
) (
    input  logic clk,
    input  logic reset,
    fence_area_if.slave bus
);
    typedef enum logic [1:0] {
        S_COLLECT,
        S_ACCUM,
        S_FINAL
    } state_t;

    state_t state, state_nx;

    logic signed [7:0]  vx [NV];
    logic signed [7:0]  vy [NV];
    logic [2:0]         cnt;
    logic [2:0]         k;
    logic [2:0]         kp;
    logic signed [19:0] acc;
    logic signed [19:0] acc_abs;
    logic signed [15:0] p0;
    logic signed [15:0] p1;
    logic signed [16:0] term;
    logic               take;
    logic               last_v;
    logic               last_k;
    logic               busy_nx;

    assign take   = (state == S_COLLECT) && bus.in_valid;
    assign last_v = (cnt == 3'(NV - 1));
    assign last_k = (k == 3'(NV - 1));
    assign kp     = last_k ? 3'd0 : k + 3'd1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_COLLECT;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_COLLECT: if (take && last_v) state_nx = S_ACCUM;
            S_ACCUM:   if (last_k)         state_nx = S_FINAL;
            S_FINAL:                       state_nx = S_COLLECT;
            default:                       state_nx = S_COLLECT;
        endcase
    end

    // Output / datapath combinational terms
    always_comb begin
        p0      = 16'(vx[k]) * 16'(vy[kp]);
        p1      = 16'(vx[kp]) * 16'(vy[k]);
        term    = 17'(p0) - 17'(p1);
        acc_abs = acc[19] ? -acc : acc;
        busy_nx = (state_nx != S_COLLECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NV; i++) begin
                vx[i] <= '0;
                vy[i] <= '0;
            end
            cnt            <= '0;
            k              <= '0;
            acc            <= '0;
            bus.busy       <= 1'b0;
            bus.area       <= '0;
            bus.area_half  <= 1'b0;
            bus.ccw        <= 1'b0;
            bus.area_valid <= 1'b0;
        end else begin
            bus.busy       <= busy_nx;
            bus.area_valid <= (state == S_FINAL);
            unique case (state)
                S_COLLECT: begin
                    if (take) begin
                        vx[cnt] <= bus.inX;
                        vy[cnt] <= bus.inY;
                        cnt     <= last_v ? 3'd0 : cnt + 3'd1;
                        if (last_v) begin
                            k   <= '0;
                            acc <= '0;
                        end
                    end
                end
                S_ACCUM: begin
                    acc <= acc + 20'(term);
                    k   <= last_k ? 3'd0 : k + 3'd1;
                end
                S_FINAL: begin
                    bus.area      <= acc_abs[19:1];
                    bus.area_half <= acc[0];
                    bus.ccw       <= !acc[19] && (acc != '0);
                end
                default: ;
            endcase
        end
    end
endmodule
